// File: rtl/iq_pkg.sv
// Shared types for the instruction prefetch queue: word widths and the
// buffered entry format (word address paired with its instruction).
package iq_pkg;

  localparam int INSTR_W = 32;
  localparam int IADDR_W = 30;

  typedef struct packed {
    logic [IADDR_W-1:0] addr;
    logic [INSTR_W-1:0] instr;
  } iq_entry_t;

  function automatic iq_entry_t iq_pack(input logic [IADDR_W-1:0] addr,
                                        input logic [INSTR_W-1:0] instr);
    iq_entry_t e;
    e.addr  = addr;
    e.instr = instr;
    return e;
  endfunction

endpackage

// File: rtl/iq_ptr.sv
// Wrapping circular-buffer pointer with increment and synchronous clear.
// Wrap relies on the pointer width matching log2 of a power-of-two depth.
module iq_ptr #(
  parameter int PTR_W = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             inc,
  output logic [PTR_W-1:0] ptr
);

  logic [PTR_W-1:0] ptr_q;
  logic [PTR_W-1:0] ptr_d;

  // Next pointer: clear wins over increment.
  always_comb begin
    ptr_d = ptr_q;
    if (clr) begin
      ptr_d = '0;
    end else if (inc) begin
      ptr_d = ptr_q + {{(PTR_W-1){1'b0}}, 1'b1};
    end else begin
      ptr_d = ptr_q;
    end
  end

  // Pointer register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr = ptr_q;

endmodule

// File: rtl/inst_queue.sv
// Instruction prefetch queue: DEPTH-entry circular buffer of {addr, instr}
// with flush. Optional same-cycle empty bypass under macro IQ_BYPASS_EN.
module inst_queue
  import iq_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [IADDR_W-1:0] in_addr,
  input  logic [INSTR_W-1:0] in_instr,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [IADDR_W-1:0] out_addr,
  output logic [INSTR_W-1:0] out_instr,
  input  logic               flush,
  output logic [CNT_W-1:0]   count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] ONE_CNT  = {{(CNT_W-1){1'b0}}, 1'b1};

  iq_entry_t        mem_q [DEPTH];
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;
  logic [PTR_W-1:0] rd_ptr_s;
  logic [PTR_W-1:0] wr_ptr_s;
  logic             have_s;
  logic             byp_s;
  logic             push_s;
  logic             pop_s;
  iq_entry_t        in_entry_s;
  iq_entry_t        head_s;

  // Handshake decode and head selection.
  always_comb begin
    in_entry_s = iq_pack(in_addr, in_instr);
    have_s     = (count_q != '0);
    in_ready   = rst_n && (count_q != FULL_CNT);
`ifdef IQ_BYPASS_EN
    byp_s      = rst_n && !have_s && in_valid && !flush;
`else
    byp_s      = 1'b0;
`endif
    out_valid  = (have_s || byp_s) && !flush;
    pop_s      = have_s && out_ready && !flush;
    // A bypassed word taken by decode this cycle is never stored.
    push_s     = in_valid && in_ready && !flush && !(byp_s && out_ready);
    if (!out_valid) begin
      head_s = '0;
    end else if (have_s) begin
      head_s = mem_q[rd_ptr_s];
    end else begin
      head_s = in_entry_s;
    end
    out_addr  = head_s.addr;
    out_instr = head_s.instr;
  end

  // Occupancy next state.
  always_comb begin
    count_d = count_q;
    if (flush) begin
      count_d = '0;
    end else begin
      case ({push_s, pop_s})
        2'b10:   count_d = count_q + ONE_CNT;
        2'b01:   count_d = count_q - ONE_CNT;
        default: count_d = count_q;
      endcase
    end
  end

  // Occupancy register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // Entry storage; contents are don't-care after reset.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_q[wr_ptr_s] <= in_entry_s;
    end
  end

  iq_ptr #(.PTR_W(PTR_W)) u_rd_ptr (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (flush),
    .inc   (pop_s),
    .ptr   (rd_ptr_s)
  );

  iq_ptr #(.PTR_W(PTR_W)) u_wr_ptr (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (flush),
    .inc   (push_s),
    .ptr   (wr_ptr_s)
  );

  assign count = count_q;

endmodule

// File: tb/tb_inst_queue.sv
// Randomized bench for inst_queue with a FIFO-queue reference model plus
// directed scenarios carrying hand-computed expectations.
module tb_inst_queue;
  import iq_pkg::*;

  localparam int DEPTH = 4;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic               clk = 1'b0;
  logic               rst_n;
  logic               in_valid;
  logic               in_ready;
  logic [IADDR_W-1:0] in_addr;
  logic [INSTR_W-1:0] in_instr;
  logic               out_valid;
  logic               out_ready;
  logic [IADDR_W-1:0] out_addr;
  logic [INSTR_W-1:0] out_instr;
  logic               flush;
  logic [CNT_W-1:0]   count;

  int checks   = 0;
  int failures = 0;
  iq_entry_t mq[$];
  bit bypass_build;

  always #5 clk = ~clk;

  inst_queue #(.DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_addr   (in_addr),
    .in_instr  (in_instr),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_addr  (out_addr),
    .out_instr (out_instr),
    .flush     (flush),
    .count     (count)
  );

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic bit model_bypass();
    return bypass_build && (mq.size() == 0) && in_valid && !flush;
  endfunction

  // Apply inputs, settle, and compare every output against the model.
  task automatic drive(input bit v, input logic [29:0] a, input logic [31:0] i,
                       input bit ordy, input bit fl);
    bit        ev;
    iq_entry_t head;
    in_valid = v; in_addr = a; in_instr = i; out_ready = ordy; flush = fl;
    #1;
    ev = ((mq.size() != 0) || model_bypass()) && !fl;
    head = '0;
    if (ev) head = (mq.size() != 0) ? mq[0] : iq_pack(a, i);
    chk("count",     32'(count),     32'(mq.size()));
    chk("in_ready",  32'(in_ready),  32'(mq.size() != DEPTH));
    chk("out_valid", 32'(out_valid), 32'(ev));
    chk("out_addr",  32'(out_addr),  32'(head.addr));
    chk("out_instr", out_instr,      head.instr);
  endtask

  // Clock edge, then advance the model using the inputs that were applied.
  task automatic step();
    bit take, pop, push;
    @(posedge clk);
    if (flush) begin
      mq.delete();
    end else begin
      take = model_bypass() && out_ready;
      pop  = (mq.size() != 0) && out_ready;
      push = in_valid && (mq.size() != DEPTH) && !take;
      if (pop)  void'(mq.pop_front());
      if (push) mq.push_back(iq_pack(in_addr, in_instr));
    end
    @(negedge clk);
  endtask

  task automatic cyc(input bit v, input logic [29:0] a, input logic [31:0] i,
                     input bit ordy, input bit fl);
    drive(v, a, i, ordy, fl);
    step();
  endtask

  task automatic peek();
    in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    mq.delete();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
`ifdef IQ_BYPASS_EN
    bypass_build = 1'b1;
`else
    bypass_build = 1'b0;
`endif
    rst_n = 1'b0; in_valid = 1'b0; in_addr = '0; in_instr = '0;
    out_ready = 1'b0; flush = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    rst_n = 1'b1;
    #1;
    chk("rel_in_ready", 32'(in_ready), 32'd1);

    // Reset mid-stream between edges.
    cyc(1'b1, 30'h5, 32'h55, 1'b0, 1'b0);
    cyc(1'b1, 30'h6, 32'h66, 1'b0, 1'b0);
    peek();
    chk("pre_rst_count", 32'(count), 32'd2);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_count", 32'(count), 32'd0);
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_in_ready", 32'(in_ready), 32'd0);
    mq.delete();
    rst_n = 1'b1;
    #1;
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);
    chk("post_rst_out_instr", out_instr, 32'd0);

    // Fill to full then drain in order.
    for (int k = 0; k < DEPTH; k++) cyc(1'b1, 30'(k), 32'hA0 + 32'(k), 1'b0, 1'b0);
    peek();
    chk("full_count", 32'(count), 32'd4);
    chk("full_in_ready", 32'(in_ready), 32'd0);
    for (int k = 0; k < DEPTH; k++) begin
      out_ready = 1'b1; #1;
      chk("drain_addr", 32'(out_addr), 32'(k));
      chk("drain_instr", out_instr, 32'hA0 + 32'(k));
      cyc(1'b0, 30'h0, 32'h0, 1'b1, 1'b0);
    end
    peek();
    chk("drained_valid", 32'(out_valid), 32'd0);

    // Streaming push+pop with many wrap-arounds.
    for (int k = 0; k < 32; k++) begin
      cyc(1'b1, 30'(100 + k), 32'hC000 + 32'(k), 1'b1, 1'b0);
      if (!bypass_build) chk("stream_count", 32'(count), 32'd1);
    end
    cyc(1'b0, 30'h0, 32'h0, 1'b1, 1'b0);

    // Flush with concurrent push and pop.
    for (int k = 0; k < 3; k++) cyc(1'b1, 30'(200 + k), 32'hF0 + 32'(k), 1'b0, 1'b0);
    drive(1'b1, 30'h3FF, 32'hDEAD, 1'b1, 1'b1);
    chk("flush_out_valid", 32'(out_valid), 32'd0);
    step();
    peek();
    chk("flush_count", 32'(count), 32'd0);
    chk("flush_empty_valid", 32'(out_valid), 32'd0);
    cyc(1'b1, 30'h77, 32'h7777, 1'b0, 1'b0);
    peek();
    chk("post_flush_addr", 32'(out_addr), 32'h77);

    // Full plus pop: push refused, then accepted next cycle.
    for (int k = 0; k < 3; k++) cyc(1'b1, 30'(300 + k), 32'hB0 + 32'(k), 1'b0, 1'b0);
    drive(1'b1, 30'h1AB, 32'h1AB, 1'b1, 1'b0);
    chk("fp_in_ready", 32'(in_ready), 32'd0);
    chk("fp_head", 32'(out_addr), 32'h77);
    step();
    peek();
    chk("fp_count", 32'(count), 32'd3);
    drive(1'b1, 30'h1AB, 32'h1AB, 1'b0, 1'b0);
    chk("fp_retry_ready", 32'(in_ready), 32'd1);
    step();
    peek();
    chk("fp_count2", 32'(count), 32'd4);
    for (int k = 0; k < DEPTH; k++) cyc(1'b0, 30'h0, 32'h0, 1'b1, 1'b0);

    // Empty-queue word with decode ready.
    drive(1'b1, 30'h10, 32'h2402000A, 1'b1, 1'b0);
    if (bypass_build) begin
      chk("byp_valid", 32'(out_valid), 32'd1);
      chk("byp_instr", out_instr, 32'h2402000A);
    end else begin
      chk("nobyp_valid", 32'(out_valid), 32'd0);
    end
    step();
    peek();
    if (bypass_build) begin
      chk("byp_count", 32'(count), 32'd0);
    end else begin
      chk("nobyp_valid_after", 32'(out_valid), 32'd1);
      chk("nobyp_instr_after", out_instr, 32'h2402000A);
    end
    cyc(1'b0, 30'h0, 32'h0, 1'b1, 1'b0);

    // Randomized traffic.
    for (int n = 0; n < 600; n++) begin
      cyc(1'($urandom_range(0, 3) != 0), 30'($urandom), $urandom,
          1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 19) == 0));
      if ($urandom_range(0, 149) == 0) begin
        do_reset();
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
